// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - slave-side crossbar router: steers each packet to one master by its head-beat dest
// Two-entry skid FIFO keeps s_ready_o registered; packets with an out-of-range dest are swallowed and counted.
module stream_demux #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
    parameter int PORT_ID      = 0,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_DEST_WIDTH-1:0] s_dest_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic [M_DATA_COUNT-1:0] m_valid_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    input  logic [M_DATA_COUNT-1:0] m_ready_i,
    output logic [7:0]              drop_cnt_o,
    output logic                    busy_o
);

    localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = (T_DEST_WIDTH+1)'(M_DATA_COUNT);

    typedef enum logic [1:0] {HEAD, BODY, DROP} state_e;

    state_e                  state_q, state_d;
    logic [T_DATA_WIDTH-1:0] data_q     [2];
    logic                    last_q     [2];
    logic [T_DEST_WIDTH-1:0] ent_dest_q [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              count_q, count_d;
    logic [T_DEST_WIDTH-1:0] dest_q, dest_d;
    logic [7:0]              drop_cnt_q;
    logic                    ready_q, busy_q;

    logic                    accept, dest_ok, push, pop, drop_hit;
    logic [T_DEST_WIDTH-1:0] push_dest, head_dest;

    assign accept    = s_valid_i && ready_q;
    assign dest_ok   = {1'b0, s_dest_i} < DEST_LIMIT;
    assign head_dest = ent_dest_q[rd_ptr_q];
    // Only the targeted master's ready matters; the head blocks everything behind it.
    assign pop       = (count_q != 2'd0) && m_ready_i[head_dest];

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        push      = 1'b0;
        push_dest = dest_q;
        drop_hit  = 1'b0;
        if (accept) begin
            case (state_q)
                HEAD: begin
                    if (dest_ok) begin
                        push      = 1'b1;
                        push_dest = s_dest_i;
                        dest_d    = s_dest_i;
                        if (!s_last_i) state_d = BODY;
                    end else begin
                        drop_hit = 1'b1;
                        if (!s_last_i) state_d = DROP;
                    end
                end
                BODY: begin
                    push = 1'b1;
                    if (s_last_i) state_d = HEAD;
                end
                DROP: begin
                    if (s_last_i) state_d = HEAD;
                end
                default: state_d = HEAD;
            endcase
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HEAD;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            dest_q     <= '0;
            drop_cnt_q <= 8'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i]     <= '0;
                last_q[i]     <= 1'b0;
                ent_dest_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            if (push) begin
                data_q[wr_ptr_q]     <= s_data_i;
                last_q[wr_ptr_q]     <= s_last_i;
                ent_dest_q[wr_ptr_q] <= push_dest;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (drop_hit && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
            // Look-ahead on next count so a pop at full reopens ready one cycle later.
            ready_q <= (state_d == DROP) || (count_d < 2'd2);
            busy_q  <= (state_d != HEAD) || (count_d != 2'd0);
        end
    end

    assign s_ready_o  = ready_q;
    assign m_data_o   = data_q[rd_ptr_q];
    assign m_last_o   = last_q[rd_ptr_q];
    assign m_valid_o  = (count_q != 2'd0) ? (M_DATA_COUNT'(1) << head_dest) : '0;
    assign m_id_o     = T_ID___WIDTH'(PORT_ID);
    assign drop_cnt_o = drop_cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed self-checking bench for stream_demux
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stream_demux;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic [1:0] s_dest;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [2:0] m_valid;
    logic [0:0] m_id;
    logic [2:0] m_ready;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks;
    int failures;

    stream_demux #(
        .T_DATA_WIDTH(8),
        .S_DATA_COUNT(2),
        .M_DATA_COUNT(3),
        .PORT_ID(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_dest_i  (s_dest),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_id_o    (m_id),
        .m_ready_i (m_ready),
        .drop_cnt_o(drop_cnt),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] de, input logic l);
        s_valid = v;
        s_data  = d;
        s_dest  = de;
        s_last  = l;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        m_ready = 3'b000;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        repeat (3) tick;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
        checks++; if (m_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", m_valid); end
        checks++; if (m_data !== 8'h00 || m_last !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%b exp=00/0", m_data, m_last); end
        checks++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_busy_drop got=%b/%0d exp=0/0", busy, drop_cnt); end
        checks++; if (m_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b exp=0", m_id); end
        rst_n = 1'b1;
        tick;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_stream;
        m_ready = 3'b010;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 2'd1, i == 3);
            tick;
            checks++; if (m_valid !== 3'b010) begin failures++; $display("FAIL stream_valid beat=%0d got=%b exp=010", i, m_valid); end
            checks++; if (m_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i, m_data, 8'h10 + 8'(i)); end
            checks++; if (m_last !== (i == 3)) begin failures++; $display("FAIL stream_last beat=%0d got=%b exp=%b", i, m_last, i == 3); end
            checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL stream_ready_busy beat=%0d got=%b/%b exp=1/1", i, s_ready, busy); end
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b/%b exp=000/0", m_valid, busy); end
    endtask

    task automatic test_backpressure;
        m_ready = 3'b000;
        drive(1'b1, 8'h20, 2'd2, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b100 || m_data !== 8'h20 || s_ready !== 1'b1) begin failures++; $display("FAIL bp_first got=%b/%h/%b exp=100/20/1", m_valid, m_data, s_ready); end
        drive(1'b1, 8'h21, 2'd2, 1'b0);
        tick;
        checks++; if (s_ready !== 1'b0 || m_data !== 8'h20) begin failures++; $display("FAIL bp_full got=%b/%h exp=0/20", s_ready, m_data); end
        drive(1'b1, 8'h22, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (s_ready !== 1'b0 || m_valid !== 3'b100 || m_data !== 8'h20) begin failures++; $display("FAIL bp_stall cyc=%0d got=%b/%b/%h exp=0/100/20", i, s_ready, m_valid, m_data); end
        end
        m_ready = 3'b100;
        tick;
        checks++; if (m_data !== 8'h21 || s_ready !== 1'b1) begin failures++; $display("FAIL bp_pop1 got=%h/%b exp=21/1", m_data, s_ready); end
        tick;
        checks++; if (m_data !== 8'h22 || m_last !== 1'b0 || m_valid !== 3'b100) begin failures++; $display("FAIL bp_pop2 got=%h/%b/%b exp=22/0/100", m_data, m_last, m_valid); end
        drive(1'b1, 8'h23, 2'd2, 1'b1);
        tick;
        checks++; if (m_data !== 8'h23 || m_last !== 1'b1 || m_valid !== 3'b100) begin failures++; $display("FAIL bp_pop3 got=%h/%b/%b exp=23/1/100", m_data, m_last, m_valid); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b/%b exp=000/0", m_valid, busy); end
    endtask

    task automatic test_dest_lock;
        m_ready = 3'b001;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h30 + 8'(i), (i == 0) ? 2'd0 : 2'd2, i == 2);
            tick;
            checks++; if (m_valid !== 3'b001 || m_data !== 8'h30 + 8'(i)) begin failures++; $display("FAIL lock beat=%0d got=%b/%h exp=001/%h", i, m_valid, m_data, 8'h30 + 8'(i)); end
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000) begin failures++; $display("FAIL lock_drain got=%b exp=000", m_valid); end
    endtask

    task automatic test_invalid_dest;
        m_ready = 3'b111;
        drive(1'b1, 8'h40, 2'd3, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || drop_cnt !== 8'd1) begin failures++; $display("FAIL inv_head got=%b/%0d exp=000/1", m_valid, drop_cnt); end
        checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL inv_drop_state got=%b/%b exp=1/1", s_ready, busy); end
        drive(1'b1, 8'h41, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || s_ready !== 1'b1) begin failures++; $display("FAIL inv_body got=%b/%b exp=000/1", m_valid, s_ready); end
        drive(1'b1, 8'h42, 2'd0, 1'b1);
        tick;
        checks++; if (m_valid !== 3'b000 || drop_cnt !== 8'd1) begin failures++; $display("FAIL inv_tail got=%b/%0d exp=000/1", m_valid, drop_cnt); end
        drive(1'b1, 8'h50, 2'd0, 1'b1);
        tick;
        checks++; if (m_valid !== 3'b001 || m_data !== 8'h50) begin failures++; $display("FAIL inv_next got=%b/%h exp=001/50", m_valid, m_data); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL inv_drain got=%b/%b exp=000/0", m_valid, busy); end
        drive(1'b1, 8'h5A, 2'd3, 1'b1);
        repeat (253) tick;
        checks++; if (drop_cnt !== 8'd254) begin failures++; $display("FAIL inv_count got=%0d exp=254", drop_cnt); end
        repeat (3) tick;
        checks++; if (drop_cnt !== 8'd255 || m_valid !== 3'b000) begin failures++; $display("FAIL inv_saturate got=%0d/%b exp=255/000", drop_cnt, m_valid); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
    endtask

    task automatic test_back_to_back;
        m_ready = 3'b010;
        drive(1'b1, 8'h60, 2'd0, 1'b1);
        tick;
        checks++; if (m_valid !== 3'b001 || m_data !== 8'h60) begin failures++; $display("FAIL b2b_first got=%b/%h exp=001/60", m_valid, m_data); end
        drive(1'b1, 8'h61, 2'd1, 1'b1);
        tick;
        checks++; if (m_valid !== 3'b001 || m_data !== 8'h60 || s_ready !== 1'b0) begin failures++; $display("FAIL b2b_blocked got=%b/%h/%b exp=001/60/0", m_valid, m_data, s_ready); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b001 || m_data !== 8'h60) begin failures++; $display("FAIL b2b_hold got=%b/%h exp=001/60", m_valid, m_data); end
        m_ready = 3'b011;
        tick;
        checks++; if (m_valid !== 3'b010 || m_data !== 8'h61) begin failures++; $display("FAIL b2b_second got=%b/%h exp=010/61", m_valid, m_data); end
        tick;
        checks++; if (m_valid !== 3'b000) begin failures++; $display("FAIL b2b_drain got=%b exp=000", m_valid); end
    endtask

    task automatic test_reset_mid_packet;
        m_ready = 3'b000;
        drive(1'b1, 8'h70, 2'd1, 1'b0);
        tick;
        drive(1'b1, 8'h71, 2'd1, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b010 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b/%b exp=010/1", m_valid, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 3'b000 || s_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=%b/%b/%b exp=000/0/0", m_valid, s_ready, busy); end
        checks++; if (drop_cnt !== 8'd0 || m_data !== 8'h00) begin failures++; $display("FAIL rst_mid_clear got=%0d/%h exp=0/00", drop_cnt, m_data); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (s_ready !== 1'b1 || m_valid !== 3'b000) begin failures++; $display("FAIL rst_mid_release got=%b/%b exp=1/000", s_ready, m_valid); end
        m_ready = 3'b100;
        drive(1'b1, 8'h80, 2'd2, 1'b1);
        tick;
        checks++; if (m_valid !== 3'b100 || m_data !== 8'h80 || m_last !== 1'b1) begin failures++; $display("FAIL rst_mid_head got=%b/%h/%b exp=100/80/1", m_valid, m_data, m_last); end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        tick;
        checks++; if (m_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_drain got=%b/%b exp=000/0", m_valid, busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_stream;
        test_backpressure;
        test_dest_lock;
        test_invalid_dest;
        test_back_to_back;
        test_reset_mid_packet;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Slave-side routing stage of the crossbar: each slave input port gets one instance, which steers its packet stream to one of M_DATA_COUNT master-side arbiters by the destination carried on the first beat. It holds the destination for the whole packet, buffers up to two beats in a skid buffer so `s_ready_o` is registered, and drops packets whose destination is out of range. Outputs feed the per-master arbiters, which select among slave ports and return `ready` per master.

## Interface
- `T_DATA_WIDTH`, 8: data beat width.
- `S_DATA_COUNT`, 2: number of slave ports (≥2); sets `T_ID___WIDTH = $clog2(S_DATA_COUNT)`.
- `M_DATA_COUNT`, 3: number of master ports (≥2); sets `T_DEST_WIDTH = $clog2(M_DATA_COUNT)`.
- `PORT_ID`, 0: index of this slave port, `0..S_DATA_COUNT-1`.
- `clk`  in  1  clock; every flop is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data_i`  in  T_DATA_WIDTH  input beat data.
- `s_dest_i`  in  T_DEST_WIDTH  destination master; sampled only on a packet's first beat.
- `s_last_i`  in  1  last beat of the packet.
- `s_valid_i`  in  1  input beat valid.
- `s_ready_o`  out  1  registered ready; a beat transfers when `s_valid_i && s_ready_o`.
- `m_data_o`  out  T_DATA_WIDTH  head-of-buffer data, broadcast to all masters.
- `m_last_o`  out  1  head-of-buffer last flag.
- `m_valid_o`  out  M_DATA_COUNT  one-hot; bit k set when the head beat is valid and targets master k.
- `m_id_o`  out  T_ID___WIDTH  constant `PORT_ID`.
- `m_ready_i`  in  M_DATA_COUNT  per-master ready from the arbiters.
- `drop_cnt_o`  out  8  number of dropped packets; saturates at 255.
- `busy_o`  out  1  high while a packet is in progress (state BODY or DROP) or the buffer is non-empty.

## Operation
- **Buffer:** 2-entry FIFO. Each entry holds {data, last, dest}. `count` runs 0..2.
- **Push:** a beat is written when `s_valid_i && s_ready_o` and the state is not DROP, and the beat is not an invalid head.
- **Pop:** the head pops when `count != 0` and `m_ready_i[head.dest]` is high. Ready bits of other masters are ignored.
- **Output:** `m_valid_o` is `(count != 0) << head.dest`. `m_data_o` and `m_last_o` show the head entry. Outputs hold stable while not popped.
- **FSM states:**
  - HEAD (reset state): the next accepted beat is a first beat.
    - If its dest is `< M_DATA_COUNT`: lock `dest_q = s_dest_i` and push with that dest. Go to BODY if `!s_last_i`; otherwise stay in HEAD.
    - If its dest is `>= M_DATA_COUNT`: do not push; increment `drop_cnt_o` (saturating). Go to DROP if `!s_last_i`; otherwise stay in HEAD.
  - BODY: each accepted beat is pushed with `dest_q`, ignoring `s_dest_i`. An accepted beat with `s_last_i` returns the FSM to HEAD.
  - DROP: accepted beats are discarded. An accepted beat with `s_last_i` returns the FSM to HEAD. `s_ready_o` is forced to 1 from the cycle after entry until exit.
- **Ready rule:** `s_ready_o <= (state_next == DROP) || (count_next < 2)`. Here `count_next` includes this cycle's push and pop, so a pop at count 2 reopens ready on the next cycle.
- **Push and pop in the same cycle:** `count` is unchanged; FIFO order is preserved.
- **Power-of-two `M_DATA_COUNT`:** no dest is invalid and DROP is unreachable.
- **Reset:**
  - Applies immediately, including mid-packet.
  - Clears: buffer, `count = 0`, state HEAD, `dest_q = 0`, `drop_cnt_o = 0`.
  - Output values during reset: `m_valid_o = 0`, `m_last_o = 0`, `m_data_o = 0`, `busy_o = 0`, `s_ready_o = 0`.
  - After release, the first beat seen is treated as a head.

## Timing
- `s_ready_o` rises on the first `clk` edge after `rst_n` deasserts.
- Latency is 1 cycle: a beat accepted at edge N is on `m_*` after edge N and can pop at edge N+1.
- Throughput is 1 beat/cycle when `m_ready_i[dest]` is held high. `count` stays at 1 and `s_ready_o` stays 1.
- With a stalled master, at most 2 beats are accepted. `s_ready_o` falls the cycle after the second push.
- A packet switches destination only at a packet boundary. Beats of consecutive packets to different masters may sit in the buffer together. The head blocks the entry behind it, so there is no reordering.
- `busy_o` and `drop_cnt_o` are registered and update on the edge of the causing event.

## Test plan
- **Streaming to one master:** 4-beat packet, dest=1, data 0x10..0x13, `m_ready_i=3'b010` held.
  - `m_valid_o=3'b010` for 4 consecutive cycles, starting 1 cycle after the first accept.
  - Data in order; `m_last_o` only with 0x13; `s_ready_o` stays 1.
- **Backpressure:** dest=2 packet, `m_ready_i=0` for 5 cycles.
  - Exactly 2 beats accepted; `s_ready_o=0` from the cycle after the 2nd accept.
  - After `m_ready_i[2]=1`, the remaining beats drain with no loss or duplication.
- **Dest lock:** 3-beat packet with dest=0 on beat 0, then `s_dest_i` toggled to 2 on beats 1–2.
  - All 3 beats appear on `m_valid_o=3'b001`; `m_valid_o[2]` never asserts.
- **Invalid dest:** `M_DATA_COUNT=3`, 3-beat packet with dest=3, then a 1-beat packet with dest=0.
  - The first packet is fully accepted and never seen on `m_valid_o`; `drop_cnt_o=1`.
  - The second packet appears on `m_valid_o[0]`.
  - 256 single-beat invalid packets → `drop_cnt_o` stays 255.
- **Back-to-back packets, different masters:** 1-beat dest=0 followed immediately by 1-beat dest=1; `m_ready_i[0]=0`, `m_ready_i[1]=1`.
  - `m_valid_o=3'b001` holds; the dest=1 beat waits behind it (no bypass).
  - Releasing `m_ready_i[0]` gives `3'b001` then `3'b010` on successive cycles.
- **Reset mid-packet:** assert `rst_n=0` after beat 2 of a 4-beat dest=1 packet.
  - `m_valid_o=0`, `s_ready_o=0`, `busy_o=0` immediately.
  - After release, a beat with dest=2 routes to master 2.
